// File: rtl/sat_agc_pkg.sv
// Shared types and elaboration helpers for the sat_agc gain controller.
package sat_agc_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    QUIET  = 2'd1,
    FROZEN = 2'd2
  } agc_state_t;

  function automatic int shift_w(input int max_shift);
    return $clog2(max_shift + 1);
  endfunction

  function automatic bit params_ok(input int dw, input int ow, input int max_shift,
                                   input int init_shift, input int win, input int alarm_th);
    return (dw >= 1) && (ow >= 2) && (ow < dw + max_shift) && (init_shift >= 0) &&
           (init_shift <= max_shift) && (win >= 2) && (alarm_th >= 1);
  endfunction

endpackage

// File: rtl/sat_agc_sat.sv
// Signed saturation from IW bits down to OW bits, with an overflow flag.
module sat_agc_sat #(
  parameter int IW = 24,
  parameter int OW = 16
) (
  input  logic signed [IW-1:0] x,
  output logic signed [OW-1:0] y,
  output logic                 sat
);

  localparam logic [OW-1:0] MAX_V = {1'b0, {(OW-1){1'b1}}};
  localparam logic [OW-1:0] MIN_V = {1'b1, {(OW-1){1'b0}}};

  // The value fits only when every bit above the output sign equals that sign.
  logic [IW-OW:0] top;
  assign top = x[IW-1:OW-1];

  always_comb begin
    sat = !((&top) || !(|top));
    y   = x[OW-1:0];
    if (sat) begin
      y = x[IW-1] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/sat_agc.sv
// Shift-gain stage plus saturation, with windowed overload counting that steers the shift.
module sat_agc
  import sat_agc_pkg::*;
#(
  parameter int DW           = 16,
  parameter int OW           = 16,
  parameter int MAX_SHIFT    = 8,
  parameter int INIT_SHIFT   = 4,
  parameter int WIN          = 1024,
  parameter int ALARM_TH     = 4,
  parameter int RECOVER_WINS = 8
) (
  input  logic                          clk_i,
  input  logic                          srst_n_i,
  input  logic [DW-1:0]                 x_i,
  input  logic                          valid_i,
  input  logic                          freeze_i,
  input  logic                          load_i,
  input  logic [shift_w(MAX_SHIFT)-1:0] load_shift_i,
  output logic [OW-1:0]                 y_o,
  output logic                          valid_o,
  output logic                          sat_alarm_o,
  output logic [shift_w(MAX_SHIFT)-1:0] shift_o,
  output logic                          gain_change_o
);

  localparam int SW = shift_w(MAX_SHIFT);
  localparam int IW = DW + MAX_SHIFT;
  localparam int WW = $clog2(WIN);
  localparam int AW = $clog2(ALARM_TH + 1);
  localparam int QW = $clog2(RECOVER_WINS + 2);

  localparam logic [SW-1:0] MAX_S  = SW'(MAX_SHIFT);
  localparam logic [SW-1:0] INIT_S = SW'(INIT_SHIFT);
  localparam logic [WW-1:0] WLAST  = WW'(WIN - 1);
  localparam logic [AW-1:0] ATH    = AW'(ALARM_TH);
  localparam logic [QW-1:0] QRW    = QW'(RECOVER_WINS);

  if (!params_ok(DW, OW, MAX_SHIFT, INIT_SHIFT, WIN, ALARM_TH)) begin : g_bad_params
    $error("sat_agc: illegal parameter combination");
  end

  logic signed [IW-1:0] s1_reg;
  logic                 s1_valid_reg;
  logic signed [IW-1:0] x_ext;
  logic signed [OW-1:0] sat_y;
  logic                 sat_flag;
  logic [OW-1:0]        y_reg;
  logic                 valid_reg;
  logic                 alarm_reg;
  logic [SW-1:0]        shift_reg;
  logic                 gc_reg;
  logic [QW-1:0]        quiet_reg;
  agc_state_t           state_reg;
  logic [WW-1:0]        win_cnt_reg;
  logic [AW-1:0]        alarm_cnt_reg;

  assign x_ext = {{MAX_SHIFT{x_i[DW-1]}}, x_i};

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      s1_reg       <= '0;
      s1_valid_reg <= 1'b0;
    end else begin
      s1_valid_reg <= valid_i;
      if (valid_i) begin
        s1_reg <= x_ext <<< shift_reg;
      end
    end
  end

  sat_agc_sat #(.IW(IW), .OW(OW)) u_sat (
    .x   (s1_reg),
    .y   (sat_y),
    .sat (sat_flag)
  );

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      y_reg     <= '0;
      valid_reg <= 1'b0;
      alarm_reg <= 1'b0;
    end else begin
      valid_reg <= s1_valid_reg;
      alarm_reg <= s1_valid_reg & sat_flag;
      if (s1_valid_reg) begin
        y_reg <= sat_y;
      end
    end
  end

  // Alarm count including the sample currently on the output, saturating at the threshold.
  logic          eow;
  logic [AW-1:0] alarm_sum;
  assign eow       = valid_reg && (win_cnt_reg == WLAST);
  assign alarm_sum = (valid_reg && alarm_reg && (alarm_cnt_reg != ATH)) ?
                     alarm_cnt_reg + AW'(1) : alarm_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      win_cnt_reg   <= '0;
      alarm_cnt_reg <= '0;
    end else if (valid_reg) begin
      if (eow) begin
        win_cnt_reg   <= '0;
        alarm_cnt_reg <= '0;
      end else begin
        win_cnt_reg   <= win_cnt_reg + WW'(1);
        alarm_cnt_reg <= alarm_sum;
      end
    end
  end

  logic [SW-1:0] eval_shift;
  logic [QW-1:0] eval_quiet;
  logic [QW-1:0] quiet_inc;
  agc_state_t    eval_state;
  logic [SW-1:0] load_val;

  assign quiet_inc = quiet_reg + QW'(1);
  assign load_val  = (load_shift_i > MAX_S) ? MAX_S : load_shift_i;

  always_comb begin
    eval_shift = shift_reg;
    eval_quiet = '0;
    eval_state = NORMAL;
    if (alarm_sum == ATH) begin
      eval_shift = (shift_reg == '0) ? shift_reg : shift_reg - SW'(1);
    end else if (alarm_sum == '0) begin
      if (quiet_inc >= QRW) begin
        eval_shift = (shift_reg == MAX_S) ? shift_reg : shift_reg + SW'(1);
      end else begin
        eval_quiet = quiet_inc;
        eval_state = QUIET;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      shift_reg <= INIT_S;
      gc_reg    <= 1'b0;
      quiet_reg <= '0;
      state_reg <= NORMAL;
    end else begin
      gc_reg <= 1'b0;
      if (load_i) begin
        shift_reg <= load_val;
        gc_reg    <= (load_val != shift_reg);
        quiet_reg <= '0;
        state_reg <= freeze_i ? FROZEN : NORMAL;
      end else if (freeze_i) begin
        quiet_reg <= '0;
        state_reg <= FROZEN;
      end else if (eow) begin
        shift_reg <= eval_shift;
        gc_reg    <= (eval_shift != shift_reg);
        quiet_reg <= eval_quiet;
        state_reg <= eval_state;
      end else if (state_reg == FROZEN) begin
        state_reg <= NORMAL;
      end
    end
  end

  assign y_o           = y_reg;
  assign valid_o       = valid_reg;
  assign sat_alarm_o   = alarm_reg;
  assign shift_o       = shift_reg;
  assign gain_change_o = gc_reg;

endmodule

// File: tb/tb_sat_agc.sv
// Directed bench for sat_agc: expected samples are queued at issue time and matched by a monitor.
module tb_sat_agc;

  logic        clk = 1'b0;
  logic        srst_n;
  logic [15:0] x;
  logic        valid;
  logic        freeze;
  logic        load;
  logic [3:0]  load_shift;
  logic [15:0] y;
  logic        valid_o;
  logic        alarm;
  logic [3:0]  shift;
  logic        gc;

  always #5 clk = ~clk;

  sat_agc #(
    .DW(16), .OW(16), .MAX_SHIFT(8), .INIT_SHIFT(4),
    .WIN(16), .ALARM_TH(4), .RECOVER_WINS(2)
  ) dut (
    .clk_i         (clk),
    .srst_n_i      (srst_n),
    .x_i           (x),
    .valid_i       (valid),
    .freeze_i      (freeze),
    .load_i        (load),
    .load_shift_i  (load_shift),
    .y_o           (y),
    .valid_o       (valid_o),
    .sat_alarm_o   (alarm),
    .shift_o       (shift),
    .gain_change_o (gc)
  );

  typedef struct {
    logic [15:0] ey;
    logic        ea;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;
  int exp_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every presented output sample must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (gc === 1'b1) pulses++;
    if (valid_o === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        failures++;
        $display("FAIL unexpected_sample: got y=%h alarm=%b, no sample expected", y, alarm);
      end else begin
        e = sbq.pop_front();
        $display("txn cyc=%0d y=%h alarm=%b shift=%0d", cyc, y, alarm, shift);
        if (y !== e.ey || alarm !== e.ea || cyc != e.cyc) begin
          failures++;
          $display("FAIL sample: got y=%h alarm=%b cyc=%0d, expected y=%h alarm=%b cyc=%0d",
                   y, alarm, cyc, e.ey, e.ea, e.cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] xv, input logic [15:0] ey, input logic ea);
    x = xv;
    valid = 1'b1;
    sbq.push_back('{ey, ea, cyc + 2});
    tick();
    valid = 1'b0;
  endtask

  task automatic do_reset();
    srst_n = 1'b0;
    valid = 1'b0;
    tick();
    chk("rst_y", 32'(y), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_alarm", 32'(alarm), 32'h0);
    chk("rst_gc", 32'(gc), 32'h0);
    chk("rst_shift", 32'(shift), 32'd4);
    srst_n = 1'b1;
    sbq.delete();
  endtask

  // One 16-sample window: first na samples are (xa -> ya, alarm), the rest (xq -> yq, quiet).
  task automatic window(input logic [15:0] xa, input logic [15:0] ya, input int na,
                        input logic [15:0] xq, input logic [15:0] yq,
                        input int exp_shift, input logic exp_gc);
    for (int i = 0; i < 16; i++) begin
      if (i < na) send(xa, ya, 1'b1);
      else        send(xq, yq, 1'b0);
    end
    tick();
    chk("gc_before_update", 32'(gc), 32'h0);
    tick();
    chk("win_shift", 32'(shift), 32'(exp_shift));
    chk("win_gc", 32'(gc), 32'(exp_gc));
    if (exp_gc) exp_pulses++;
  endtask

  initial begin
    srst_n = 1'b0; x = '0; valid = 1'b0; freeze = 1'b0; load = 1'b0; load_shift = '0;
    tick();
    do_reset();

    // Basic gain and latency
    send(16'h0001, 16'h0010, 1'b0);
    tick(); tick();
    chk("t1_shift", 32'(shift), 32'd4);
    chk("t1_gc", 32'(gc), 32'h0);

    // Overload walks the shift down to 0; at shift 0 nothing saturates
    do_reset();
    window(16'h4000, 16'h7FFF, 16, 16'h0, 16'h0, 3, 1'b1);
    window(16'h4000, 16'h7FFF, 16, 16'h0, 16'h0, 2, 1'b1);
    window(16'h4000, 16'h7FFF, 16, 16'h0, 16'h0, 1, 1'b1);
    window(16'h4000, 16'h7FFF, 16, 16'h0, 16'h0, 0, 1'b1);
    window(16'h0, 16'h0, 0, 16'h4000, 16'h4000, 0, 1'b0);

    // Quiet windows raise the shift every second window, capping at 8
    do_reset();
    window(16'h0, 16'h0, 0, 16'h0100, 16'h1000, 4, 1'b0);
    window(16'h0, 16'h0, 0, 16'h0100, 16'h1000, 5, 1'b1);
    window(16'h0, 16'h0, 0, 16'h0010, 16'h0200, 5, 1'b0);
    window(16'h0, 16'h0, 0, 16'h0010, 16'h0200, 6, 1'b1);
    window(16'h0, 16'h0, 0, 16'h0010, 16'h0400, 6, 1'b0);
    window(16'h0, 16'h0, 0, 16'h0010, 16'h0400, 7, 1'b1);
    window(16'h0, 16'h0, 0, 16'h0010, 16'h0800, 7, 1'b0);
    window(16'h0, 16'h0, 0, 16'h0010, 16'h0800, 8, 1'b1);
    window(16'h0, 16'h0, 0, 16'h0010, 16'h1000, 8, 1'b0);
    window(16'h0, 16'h0, 0, 16'h0010, 16'h1000, 8, 1'b0);

    // Negative overload; a 3-alarm window clears the quiet run
    do_reset();
    window(16'h0, 16'h0, 0, 16'h0001, 16'h0010, 4, 1'b0);
    window(16'h8000, 16'h8000, 3, 16'h0001, 16'h0010, 4, 1'b0);
    window(16'h0, 16'h0, 0, 16'h0001, 16'h0010, 4, 1'b0);
    window(16'h0, 16'h0, 0, 16'h0001, 16'h0010, 5, 1'b1);

    // Freeze holds the gain; load clamps to MAX_SHIFT
    do_reset();
    freeze = 1'b1;
    window(16'h4000, 16'h7FFF, 16, 16'h0, 16'h0, 4, 1'b0);
    window(16'h4000, 16'h7FFF, 16, 16'h0, 16'h0, 4, 1'b0);
    window(16'h4000, 16'h7FFF, 16, 16'h0, 16'h0, 4, 1'b0);
    freeze = 1'b0;
    load = 1'b1; load_shift = 4'd15;
    tick();
    load = 1'b0;
    chk("load_clamp_shift", 32'(shift), 32'd8);
    chk("load_clamp_gc", 32'(gc), 32'h1);
    exp_pulses++;
    tick();
    chk("load_gc_off", 32'(gc), 32'h0);

    // Load coincident with end of an overload window wins
    do_reset();
    for (int i = 0; i < 16; i++) send(16'h4000, 16'h7FFF, 1'b1);
    tick();
    load = 1'b1; load_shift = 4'd6;
    tick();
    load = 1'b0;
    chk("load_eow_shift", 32'(shift), 32'd6);
    chk("load_eow_gc", 32'(gc), 32'h1);
    exp_pulses++;
    tick();
    chk("load_eow_hold", 32'(shift), 32'd6);
    chk("load_eow_gc_off", 32'(gc), 32'h0);

    // Mid-window reset discards the partial window and in-flight samples
    for (int i = 0; i < 5; i++) send(16'h4000, 16'h7FFF, 1'b1);
    do_reset();
    window(16'h4000, 16'h7FFF, 16, 16'h0, 16'h0, 3, 1'b1);

    tick(); tick(); tick();
    chk("pulse_total", 32'(pulses), 32'(exp_pulses));
    chk("queue_drained", 32'(sbq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sat_agc.md
Name: sat_agc

Overview:
- Automatic gain controller wrapped around one `sat` saturation instance in the SDFT sample path.
- Applies a left-shift gain to each input sample, then saturates the result to the output width.
- Counts saturation events per window of samples and adjusts the shift at each window boundary: lower the gain on overload, raise it after sustained quiet.
- Sits between the input sample stream and the SDFT core.

Parameters:
- DW, 16: input sample width, signed.
- OW, 16: output sample width, signed. Must satisfy OW < DW+MAX_SHIFT.
- MAX_SHIFT, 8: maximum gain shift.
- INIT_SHIFT, 4: shift value after reset. Must be <= MAX_SHIFT.
- WIN, 1024: samples per evaluation window. Must be >= 2.
- ALARM_TH, 4: alarms per window at or above which the gain is lowered. Must be >= 1.
- RECOVER_WINS, 8: number of consecutive zero-alarm windows before the gain is raised.

Ports:
- clk_i  in  1  clock.
- srst_n_i  in  1  reset; synchronous, active-low.
- x_i  in  DW  input sample, signed.
- valid_i  in  1  input sample valid.
- freeze_i  in  1  level; when 1, the gain is held.
- load_i  in  1  pulse; force the shift to load_shift_i.
- load_shift_i  in  $clog2(MAX_SHIFT+1)  forced shift value; clamped to MAX_SHIFT.
- y_o  out  OW  saturated output sample.
- valid_o  out  1  output valid.
- sat_alarm_o  out  1  the sample on y_o was saturated; qualified by valid_o.
- shift_o  out  $clog2(MAX_SHIFT+1)  current gain shift.
- gain_change_o  out  1  one-cycle pulse on every shift change.

Behaviour:
Reset (srst_n_i=0 at a clock edge):
- y_o=0, valid_o=0, sat_alarm_o=0, gain_change_o=0.
- shift_o=INIT_SHIFT.
- Window counter, alarm counter and quiet counter = 0; FSM = NORMAL.
- Reset mid-window discards the partial window and all in-flight samples.

Datapath (no backpressure, latency exactly 2 cycles valid_i -> valid_o):
- Stage 1: register x_i sign-extended to DW+MAX_SHIFT bits, shifted left by shift_o as sampled in that cycle. Register valid alongside.
- Stage 2: feed the stage-1 value to `sat` with IW=DW+MAX_SHIFT and the given OW. Register y and the alarm into y_o / sat_alarm_o.
- Gaps in valid_i pass through; y_o holds its value while valid_o=0.

Window accounting (on valid_o samples only):
- The window counter counts 0..WIN-1. End-of-window (EOW) is valid_o with window count = WIN-1.
- The alarm counter increments on valid_o & sat_alarm_o and saturates at ALARM_TH (no wrap).
- At EOW, the evaluated count includes that last sample. Both counters restart at 0 on the next cycle.

FSM, evaluated at EOW:
- NORMAL, alarms >= ALARM_TH: shift -= 1 (floor 0); quiet = 0.
- NORMAL, alarms == 0: quiet += 1; go to QUIET.
- NORMAL, otherwise: quiet = 0, no change.
- QUIET, alarms == 0: quiet += 1. When quiet reaches RECOVER_WINS: shift += 1 (cap MAX_SHIFT), quiet = 0, go to NORMAL.
- QUIET, alarms != 0: apply the NORMAL rules, then go to NORMAL.
- FROZEN: entered while freeze_i=1. Windows keep counting, the shift never changes, quiet is held at 0. On freeze_i=0, go to NORMAL.

Update timing and priority:
- A new shift is visible on shift_o the cycle after EOW. It applies to the first sample entering stage 1 on or after that cycle; in-flight samples keep the old gain.
- gain_change_o pulses only when the shift value actually differs. A decrement at 0 or an increment at MAX_SHIFT does not pulse.
- Priority: reset > load_i > freeze_i > EOW update.
- load_i sets the shift the next cycle and pulses gain_change_o if the value differs. It also clears quiet, goes to NORMAL (or FROZEN if freeze_i=1) and does not disturb the window counters.
- load_i coincident with EOW: load wins and that window's evaluation is discarded.

Decomposition:
- Package sat_agc_pkg holds: state enum (NORMAL, QUIET, FROZEN), the shift-width function $clog2(MAX_SHIFT+1), and a parameter-legality check function used in an elaboration assertion.
- Sub-module: the existing `sat` instance only. Counters and FSM stay inline.

Test Plan (WIN=16, ALARM_TH=4, RECOVER_WINS=2, DW=OW=16, MAX_SHIFT=8, INIT_SHIFT=4):
- Reset, then x=1 valid for 1 cycle -> valid_o 2 cycles later, y_o=16, sat_alarm_o=0, shift_o=4.
- 16 samples of x=0x4000 -> every y_o=0x7FFF with alarm. One cycle after the 16th valid_o: shift_o=3, gain_change_o one pulse. Repeat until shift_o=0; no pulse on further overload windows.
- 32 samples of x=0x0100 at shift 4 -> no alarms; after the 2nd window shift_o=5 with one pulse. Continued quiet -> shift stops at 8, no further pulses.
- Negative overload x=0x8000, shift 4 -> y_o=0x8000, sat_alarm_o=1. A window with 3 alarms -> no shift change, quiet reset.
- freeze_i=1 across 3 overload windows -> shift_o constant, no pulses. load_i with load_shift_i=15 -> shift_o=8.
- load_i coincident with EOW of an overload window -> shift_o = loaded value, no decrement. Reset asserted mid-window -> all outputs back to their reset values next cycle.
